// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet receiver.
// Also provides the Y-magnitude helper used by the packet decoder.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam int PKT_BYTES = 3;
    localparam int SYNC_BIT  = 3;
    localparam int YSIGN_BIT = 5;
    localparam int YOVF_BIT  = 7;
    localparam int SPEED_MAX = 255;

    // |{ysign, y_low}| as a 9-bit two's complement value, saturated to SPEED_MAX.
    // The -256 case negates to 9'h100 and is caught by the saturation compare.
    function automatic logic [7:0] y_magnitude(input logic ysign, input logic yovf,
                                               input logic [7:0] y_low);
        logic [8:0] y9;
        logic [8:0] mag9;
        y9   = {ysign, y_low};
        mag9 = ysign ? (~y9 + 9'd1) : y9;
        if (yovf || (mag9 > 9'(SPEED_MAX)))
            return 8'(SPEED_MAX);
        return mag9[7:0];
    endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: input synchronisers, ps2_clk glitch filter, falling-edge
// strobe, 11-bit frame FSM and inactivity timeout.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_pkt_busy,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_err
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic              r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
    logic              r_filt, r_filt_d;
    logic [FILT_W-1:0] r_filt_cnt;
    frame_state_e      r_state;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_par_ok;
    logic [TO_W-1:0]   r_to_cnt;

    logic w_timeout, w_strobe, w_stop_ok;

    // NOTE: synchroniser and filter reset to the idle-high line level so that
    // leaving reset can never manufacture a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_meta  <= i_ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= i_ps2_data;
            r_data_sync <= r_data_meta;
            r_filt_d    <= r_filt;
            if (r_clk_sync == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                r_filt     <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // The timeout has priority: a strobe landing in the timeout cycle is dropped.
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
    assign w_strobe  = r_filt_d & ~r_filt & ~w_timeout;
    assign w_stop_ok = r_data_sync & r_par_ok;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_timeout || w_strobe || (r_state == IDLE && !i_pkt_busy))
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_timeout) begin
                r_state <= IDLE;
            end else if (w_strobe) begin
                case (r_state)
                    IDLE: if (!r_data_sync) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                    DATA: begin
                        r_shift   <= {r_data_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= PARITY;
                    end
                    PARITY: begin
                        r_par_ok <= ^{r_shift, r_data_sync};
                        r_state  <= STOP;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign o_byte_valid = w_strobe && (r_state == STOP) && w_stop_ok;
    assign o_byte_data  = r_shift;
    assign o_err        = w_timeout ||
                          (w_strobe && (((r_state == IDLE) && r_data_sync) ||
                                        ((r_state == STOP) && !w_stop_ok)));

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse packet receiver: assembles 3-byte packets and decodes Y motion into
// paddle speed/direction. Define PS2_DEADZONE_EN to zero magnitudes below DEADZONE.
module ps2_mouse_packet_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int NEW_DATA_CYCLES = 1,
    parameter int DEADZONE        = 2
) (
    input  logic       clk_25MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] paddle0_speed,
    output logic       paddle0_dir,
    output logic       new_data,
    output logic       frame_err
);

    localparam int IDX_W = $clog2(PKT_BYTES);
    localparam int ND_W  = $clog2(NEW_DATA_CYCLES + 1);
`ifdef PS2_DEADZONE_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    logic             w_byte_valid, w_err;
    logic [7:0]       w_byte_data, w_mag, w_mag_out;
    logic [IDX_W-1:0] r_idx;
    logic             r_ysign, r_yovf;
    logic [7:0]       r_speed;
    logic             r_dir, r_new_data, r_frame_err;
    logic [ND_W-1:0]  r_nd_cnt;

    ps2_byte_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_byte_rx (
        .i_clk        (clk_25MHz),
        .i_reset      (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .i_pkt_busy   (r_idx != '0),
        .o_byte_valid (w_byte_valid),
        .o_byte_data  (w_byte_data),
        .o_err        (w_err)
    );

    assign w_mag     = y_magnitude(r_ysign, r_yovf, w_byte_data);
    assign w_mag_out = (DZ_EN && (w_mag < 8'(DEADZONE))) ? 8'd0 : w_mag;

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            r_idx       <= '0;
            r_ysign     <= 1'b0;
            r_yovf      <= 1'b0;
            r_speed     <= '0;
            r_dir       <= 1'b0;
            r_new_data  <= 1'b0;
            r_nd_cnt    <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (r_new_data) begin
                if (r_nd_cnt == '0)
                    r_new_data <= 1'b0;
                else
                    r_nd_cnt <= r_nd_cnt - 1'b1;
            end

            // Any byte-level error or timeout discards the packet in progress.
            if (w_err) begin
                r_frame_err <= 1'b1;
                r_idx       <= '0;
            end else if (w_byte_valid) begin
                if (r_idx == '0) begin
                    if (w_byte_data[SYNC_BIT]) begin
                        r_ysign <= w_byte_data[YSIGN_BIT];
                        r_yovf  <= w_byte_data[YOVF_BIT];
                        r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else if (r_idx == IDX_W'(PKT_BYTES - 1)) begin
                    r_speed    <= w_mag_out;
                    r_dir      <= ~r_ysign;
                    r_new_data <= 1'b1;
                    r_nd_cnt   <= ND_W'(NEW_DATA_CYCLES - 1);
                    r_idx      <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign paddle0_speed = r_speed;
    assign paddle0_dir   = r_dir;
    assign new_data      = r_new_data;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx; PS/2 clock is sped up (32 system cycles
// per bit) so the timeout scenario fits in the cycle budget.
module tb_ps2_mouse_packet_rx;

    localparam int HALF = 16;
    localparam int GAP  = 16;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] paddle0_speed;
    logic       paddle0_dir;
    logic       new_data;
    logic       frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_fall = 0;
    int nd_count = 0;
    int nd_cycles = 0;
    int fe_count = 0;
    logic       nd_prev = 1'b0;
    logic [7:0] cap_speed = '0;
    logic       cap_dir = 1'b0;

    ps2_mouse_packet_rx dut (
        .clk_25MHz     (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .paddle0_speed (paddle0_speed),
        .paddle0_dir   (paddle0_dir),
        .new_data      (new_data),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor: counts new_data pulses/cycles and frame_err cycles.
    always @(negedge clk) begin
        if (new_data) begin
            nd_cycles++;
            if (!nd_prev) begin
                nd_count++;
                cap_speed = paddle0_speed;
                cap_dir   = paddle0_dir;
            end
        end
        nd_prev = new_data;
        if (frame_err) fe_count++;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ flip_par);
        ps2_bit(1'b1);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits - 1; i++) ps2_bit(b[i]);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (paddle0_speed !== 8'd0) begin errors++; $display("FAIL reset_speed got=%0d exp=0", paddle0_speed); end
        checks++; if (paddle0_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", paddle0_dir); end
        checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL reset_new_data got=%b exp=0", new_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (fe_count !== 0 || nd_count !== 0) begin errors++; $display("FAIL reset_release_pulses fe=%0d nd=%0d exp=0/0", fe_count, nd_count); end
    endtask

    // Hand-computed decode vectors: {byte0, byte1, byte2, speed, dir}.
    logic [7:0] v_b0 [10] = '{8'h08, 8'h28, 8'hA8, 8'h28, 8'h08, 8'h08, 8'h28, 8'h08, 8'h28, 8'h88};
    logic [7:0] v_b1 [10] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] v_b2 [10] = '{8'h05, 8'hFB, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h01, 8'hFF, 8'h03};
`ifdef PS2_DEADZONE_EN
    logic [7:0] v_spd[10] = '{8'd5, 8'd5, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd255};
`else
    logic [7:0] v_spd[10] = '{8'd5, 8'd5, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd1, 8'd1, 8'd255};
`endif
    logic       v_dir[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_decode;
        int nd0, ndc0, fe0;
        for (int k = 0; k < 10; k++) begin
            nd0 = nd_count; ndc0 = nd_cycles; fe0 = fe_count;
            send_packet(v_b0[k], v_b1[k], v_b2[k]);
            checks++; if (nd_count - nd0 !== 1) begin errors++; $display("FAIL decode%0d_pulses got=%0d exp=1", k, nd_count - nd0); end
            checks++; if (nd_cycles - ndc0 !== 1) begin errors++; $display("FAIL decode%0d_width got=%0d exp=1", k, nd_cycles - ndc0); end
            checks++; if (fe_count !== fe0) begin errors++; $display("FAIL decode%0d_frame_err got=%0d exp=0", k, fe_count - fe0); end
            checks++; if (cap_speed !== v_spd[k]) begin errors++; $display("FAIL decode%0d_speed got=%0d exp=%0d", k, cap_speed, v_spd[k]); end
            checks++; if (cap_dir !== v_dir[k]) begin errors++; $display("FAIL decode%0d_dir got=%b exp=%b", k, cap_dir, v_dir[k]); end
            checks++; if (paddle0_speed !== v_spd[k]) begin errors++; $display("FAIL decode%0d_hold got=%0d exp=%0d", k, paddle0_speed, v_spd[k]); end
        end
    endtask

    task automatic test_parity_error;
        int nd0, fe0;
        nd0 = nd_count; fe0 = fe_count;
        send_byte(8'h08, 1'b1);
        repeat (10) @(negedge clk);
        checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL parity_err_pulse got=%0d exp=1", fe_count - fe0); end
        checks++; if (nd_count !== nd0) begin errors++; $display("FAIL parity_no_new_data got=%0d exp=0", nd_count - nd0); end
        send_packet(8'h28, 8'h00, 8'hF9);
        checks++; if (nd_count - nd0 !== 1) begin errors++; $display("FAIL parity_recover_pulses got=%0d exp=1", nd_count - nd0); end
        checks++; if (cap_speed !== 8'd7 || cap_dir !== 1'b0) begin errors++; $display("FAIL parity_recover_decode got=%0d/%b exp=7/0", cap_speed, cap_dir); end
    endtask

    task automatic test_resync;
        int nd0, fe0;
        nd0 = nd_count; fe0 = fe_count;
        send_byte(8'h00, 1'b0);
        send_packet(8'h08, 8'h00, 8'h10);
        checks++; if (fe_count - fe0 !== 1) begin errors++; $display("FAIL resync_err_pulse got=%0d exp=1", fe_count - fe0); end
        checks++; if (nd_count - nd0 !== 1) begin errors++; $display("FAIL resync_pulses got=%0d exp=1", nd_count - nd0); end
        checks++; if (cap_speed !== 8'd16 || cap_dir !== 1'b1) begin errors++; $display("FAIL resync_decode got=%0d/%b exp=16/1", cap_speed, cap_dir); end
    endtask

    task automatic test_timeout;
        int nd0, fe0, waited;
        bit seen;
        nd0 = nd_count; fe0 = fe_count;
        send_byte(8'h08, 1'b0);
        send_partial(8'h00, 5);
        seen = 1'b0;
        while (!seen && (cyc - last_fall) < 60000) begin
            @(negedge clk);
            if (frame_err) seen = 1'b1;
        end
        waited = cyc - last_fall;
        checks++; if (!seen) begin errors++; $display("FAIL timeout_fired got=none exp=pulse"); end
        checks++; if (waited < 50000 || waited > 50050) begin errors++; $display("FAIL timeout_latency got=%0d exp=50000..50050", waited); end
        repeat (100) @(negedge clk);
        checks++; if (fe_count - fe0 !== 1 || nd_count !== nd0) begin errors++; $display("FAIL timeout_pulses fe=%0d nd=%0d exp=1/0", fe_count - fe0, nd_count - nd0); end
        send_packet(8'h28, 8'h00, 8'hE0);
        checks++; if (nd_count - nd0 !== 1 || cap_speed !== 8'd32 || cap_dir !== 1'b0) begin errors++; $display("FAIL timeout_recover got=%0d/%0d/%b exp=1/32/0", nd_count - nd0, cap_speed, cap_dir); end
    endtask

    task automatic test_glitch;
        int nd0, fe0;
        nd0 = nd_count; fe0 = fe_count;
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (fe_count !== fe0 || nd_count !== nd0) begin errors++; $display("FAIL glitch_no_strobe fe=%0d nd=%0d exp=0/0", fe_count - fe0, nd_count - nd0); end
        send_packet(8'h08, 8'h00, 8'h09);
        checks++; if (nd_count - nd0 !== 1 || cap_speed !== 8'd9 || fe_count !== fe0) begin errors++; $display("FAIL glitch_then_packet got=%0d/%0d exp=1/9", nd_count - nd0, cap_speed); end
    endtask

    task automatic test_reset_mid_frame;
        int nd0, fe0;
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        send_partial(8'h05, 5);
        nd0 = nd_count; fe0 = fe_count;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (paddle0_speed !== 8'd0 || paddle0_dir !== 1'b0) begin errors++; $display("FAIL midreset_outputs got=%0d/%b exp=0/0", paddle0_speed, paddle0_dir); end
        reset = 1'b0;
        repeat (200) @(negedge clk);
        checks++; if (nd_count !== nd0 || fe_count !== fe0) begin errors++; $display("FAIL midreset_no_pulse nd=%0d fe=%0d exp=0/0", nd_count - nd0, fe_count - fe0); end
        send_packet(8'h28, 8'h00, 8'hFD);
        checks++; if (nd_count - nd0 !== 1 || cap_speed !== 8'd3 || cap_dir !== 1'b0) begin errors++; $display("FAIL midreset_recover got=%0d/%0d/%b exp=1/3/0", nd_count - nd0, cap_speed, cap_dir); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_parity_error;
        test_resync;
        test_timeout;
        test_glitch;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
